// File: rtl/complete_arbiter_pkg.sv
// Shared completion types for the execute pipes, the completion arbiter and decode-issue.
package complete_arbiter_pkg;

  localparam int c_reg_addr_bits    = 5;
  localparam int c_data_bits        = 32;
  localparam int c_max_seq_num_bits = 32;

  // seq_num is sized for the widest supported tag; users keep the low p_seq_num_bits bits.
  typedef struct packed {
    logic [c_max_seq_num_bits-1:0] seq_num;
    logic [c_reg_addr_bits-1:0]    waddr;
    logic [c_data_bits-1:0]        wdata;
    logic                          wen;
  } completion_t;

  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/complete_arbiter_rr_arbiter.sv
// Round-robin grant: scans requests starting at the pointer and returns a one-hot
// grant together with the pointer to use after that grant is taken.
module rr_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int p_num_reqs = 2,
  localparam int c_pw = ptr_bits(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0] req_i,
  input  logic [c_pw-1:0]       ptr_i,
  input  logic                  en_i,
  output logic [p_num_reqs-1:0] gnt_o,
  output logic [c_pw-1:0]       ptr_nxt_o
);

  logic [c_pw:0]   cand_s;
  logic            found_s;
  logic [c_pw-1:0] gidx_s;

  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    gidx_s  = '0;
    cand_s  = '0;
    for (int k = 0; k < p_num_reqs; k++) begin
      cand_s = {1'b0, ptr_i} + (c_pw+1)'(k);
      if (cand_s >= (c_pw+1)'(p_num_reqs)) begin
        cand_s = cand_s - (c_pw+1)'(p_num_reqs);
      end else begin
        cand_s = cand_s;
      end
      for (int j = 0; j < p_num_reqs; j++) begin
        if (!found_s && en_i && req_i[j] && (cand_s == (c_pw+1)'(j))) begin
          found_s  = 1'b1;
          gnt_o[j] = 1'b1;
          gidx_s   = c_pw'(j);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  always_comb begin
    if (found_s) begin
      if (gidx_s == c_pw'(p_num_reqs - 1)) begin
        ptr_nxt_o = '0;
      end else begin
        ptr_nxt_o = gidx_s + c_pw'(1);
      end
    end else begin
      ptr_nxt_o = ptr_i;
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Shares the single completion/writeback path among the execute pipes, registering
// the round-robin winner onto the completion bus and counting contended cycles.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int p_num_pipes    = 2,
  parameter int p_seq_num_bits = 5,
  parameter int p_stat_bits    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_pipes-1:0]                req_val,
  output logic [p_num_pipes-1:0]                req_rdy,
  input  logic [p_num_pipes*p_seq_num_bits-1:0] req_seq_num,
  input  logic [p_num_pipes*5-1:0]              req_waddr,
  input  logic [p_num_pipes*32-1:0]             req_wdata,
  input  logic [p_num_pipes-1:0]                req_wen,
  output logic                                  complete_val,
  output logic [p_seq_num_bits-1:0]             complete_seq_num,
  output logic [4:0]                            complete_waddr,
  output logic [31:0]                           complete_wdata,
  output logic                                  complete_wen,
  output logic [p_stat_bits-1:0]                contention_count
);

  localparam int c_pw = ptr_bits(p_num_pipes);

  logic [c_pw-1:0]        rr_ptr_q, rr_ptr_d;
  logic [p_num_pipes-1:0] gnt_s;
  logic                   xfer_s;
  logic                   contend_s;
  completion_t            sel_s, cmp_q, cmp_d;
  logic                   val_q, val_d;
  logic [p_stat_bits-1:0] cnt_q, cnt_d;

  // The completion bus never back-pressures, so the arbiter is always enabled.
  rr_arbiter #(.p_num_reqs(p_num_pipes)) u_rr (
    .req_i     (req_val),
    .ptr_i     (rr_ptr_q),
    .en_i      (1'b1),
    .gnt_o     (gnt_s),
    .ptr_nxt_o (rr_ptr_d)
  );

  assign req_rdy   = gnt_s;
  assign xfer_s    = |(req_val & gnt_s);
  assign contend_s = (req_val & (req_val - p_num_pipes'(1))) != '0;

  always_comb begin
    sel_s = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      if (gnt_s[i]) begin
        sel_s.seq_num = c_max_seq_num_bits'(req_seq_num[i*p_seq_num_bits +: p_seq_num_bits]);
        sel_s.waddr   = req_waddr[i*c_reg_addr_bits +: c_reg_addr_bits];
        sel_s.wdata   = req_wdata[i*c_data_bits +: c_data_bits];
        sel_s.wen     = req_wen[i];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Data fields hold when idle; only complete_val tells consumers whether they are live.
  always_comb begin
    val_d = xfer_s;
    if (xfer_s) begin
      cmp_d = sel_s;
    end else begin
      cmp_d = cmp_q;
    end
    if (contend_s && (cnt_q != '1)) begin
      cnt_d = cnt_q + p_stat_bits'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      val_q    <= 1'b0;
      cmp_q    <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      val_q    <= val_d;
      cmp_q    <= cmp_d;
      cnt_q    <= cnt_d;
    end
  end

  assign complete_val     = val_q;
  assign complete_seq_num = cmp_q.seq_num[p_seq_num_bits-1:0];
  assign complete_waddr   = cmp_q.waddr;
  assign complete_wdata   = cmp_q.wdata;
  assign complete_wen     = cmp_q.wen;
  assign contention_count = cnt_q;

endmodule

// File: tb/tb_complete_arbiter.sv
// Scoreboard bench for complete_arbiter: a 2-pipe instance fully modelled, plus a 3-pipe
// instance for pointer wrap/skip and a 4-bit-counter instance for saturation.
module tb_complete_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;

  // main 2-pipe instance
  logic [1:0]  val, rdy, wen;
  logic [9:0]  seq, waddr;
  logic [63:0] wdata;
  logic        cval, cwen;
  logic [4:0]  cseq, cwaddr;
  logic [31:0] cwdata;
  logic [15:0] ccnt;

  complete_arbiter #(.p_num_pipes(2), .p_seq_num_bits(5), .p_stat_bits(16)) dut (
    .clk(clk), .rst(rst), .req_val(val), .req_rdy(rdy), .req_seq_num(seq),
    .req_waddr(waddr), .req_wdata(wdata), .req_wen(wen),
    .complete_val(cval), .complete_seq_num(cseq), .complete_waddr(cwaddr),
    .complete_wdata(cwdata), .complete_wen(cwen), .contention_count(ccnt)
  );

  // 3-pipe instance
  logic [2:0]  val3, rdy3, wen3;
  logic [14:0] seq3, waddr3;
  logic [95:0] wdata3;
  logic        cval3, cwen3;
  logic [4:0]  cseq3, cwaddr3;
  logic [31:0] cwdata3;
  logic [15:0] ccnt3;

  complete_arbiter #(.p_num_pipes(3), .p_seq_num_bits(5), .p_stat_bits(16)) dut3 (
    .clk(clk), .rst(rst), .req_val(val3), .req_rdy(rdy3), .req_seq_num(seq3),
    .req_waddr(waddr3), .req_wdata(wdata3), .req_wen(wen3),
    .complete_val(cval3), .complete_seq_num(cseq3), .complete_waddr(cwaddr3),
    .complete_wdata(cwdata3), .complete_wen(cwen3), .contention_count(ccnt3)
  );

  // 4-bit counter instance
  logic [1:0]  vals, rdys, wens;
  logic [9:0]  seqs, waddrs;
  logic [63:0] wdatas;
  logic        cvals, cwens;
  logic [4:0]  cseqs, cwaddrs;
  logic [31:0] cwdatas;
  logic [3:0]  ccnts;

  complete_arbiter #(.p_num_pipes(2), .p_seq_num_bits(5), .p_stat_bits(4)) dut_sat (
    .clk(clk), .rst(rst), .req_val(vals), .req_rdy(rdys), .req_seq_num(seqs),
    .req_waddr(waddrs), .req_wdata(wdatas), .req_wen(wens),
    .complete_val(cvals), .complete_seq_num(cseqs), .complete_waddr(cwaddrs),
    .complete_wdata(cwdatas), .complete_wen(cwens), .contention_count(ccnts)
  );

  typedef struct {
    logic [4:0]  seq;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
  } exp_t;

  exp_t exp_q[$];
  int   m_ptr = 0;
  int   m_cnt = 0;

  task automatic set_pipe(input int i, input logic [4:0] s, input logic [4:0] a,
                          input logic [31:0] d, input logic e);
    seq[i*5 +: 5]    = s;
    waddr[i*5 +: 5]  = a;
    wdata[i*32 +: 32] = d;
    wen[i]           = e;
  endtask

  // One cycle on the main instance: check against the model, then advance the model.
  task automatic step(input logic r, input logic [1:0] v);
    int         g;
    int         c;
    logic [1:0] er;
    exp_t       e;
    exp_t       x;
    rst = r;
    val = v;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < 2; k++) begin
      c = (m_ptr + k) % 2;
      if (g < 0 && v[c]) g = c;
    end
    er = 2'b00;
    if (g >= 0) er[g] = 1'b1;
    checks++;
    if (rdy !== er) begin
      errors++;
      $display("FAIL rdy: got %b expected %b (val=%b)", rdy, er, v);
    end
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if (cval !== 1'b1 || cseq !== x.seq || cwaddr !== x.waddr ||
          cwdata !== x.wdata || cwen !== x.wen) begin
        errors++;
        $display("FAIL completion: got val=%b seq=%0d waddr=%0d wdata=%h wen=%b expected val=1 seq=%0d waddr=%0d wdata=%h wen=%b",
                 cval, cseq, cwaddr, cwdata, cwen, x.seq, x.waddr, x.wdata, x.wen);
      end
    end else begin
      checks++;
      if (cval !== 1'b0) begin
        errors++;
        $display("FAIL idle_val: got %b expected 0", cval);
      end
    end
    checks++;
    if (ccnt !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL contention_count: got %0d expected %0d", ccnt, m_cnt);
    end
    if (!r) begin
      exp_q.delete();
      m_ptr = 0;
      m_cnt = 0;
    end else begin
      if (g >= 0) begin
        e.seq   = seq[g*5 +: 5];
        e.waddr = waddr[g*5 +: 5];
        e.wdata = wdata[g*32 +: 32];
        e.wen   = wen[g];
        exp_q.push_back(e);
        m_ptr = (g == 1) ? 0 : g + 1;
      end
      if (v == 2'b11 && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_pipe(0, 5'd1, 5'd10, 32'h1111_0000, 1'b1);
    set_pipe(1, 5'd2, 5'd11, 32'h2222_0000, 1'b0);
    step(1'b0, 2'b11);
    step(1'b0, 2'b11);
    step(1'b1, 2'b11);
  endtask

  task automatic test_single();
    set_pipe(1, 5'd3, 5'd5, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 2'b10);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
  endtask

  task automatic test_alternation();
    step(1'b0, 2'b00);
    set_pipe(0, 5'd8, 5'd20, 32'hA000_0000, 1'b1);
    set_pipe(1, 5'd9, 5'd21, 32'hB000_0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'b11);
      set_pipe(i % 2, 5'(10 + i), 5'(i + 1), $urandom, 1'(i % 3 != 0));
    end
    step(1'b1, 2'b00);
    checks++;
    if (ccnt !== 16'd6) begin
      errors++;
      $display("FAIL alternation_count: got %0d expected 6", ccnt);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] vseq [4];
    logic [2:0] gexp [4];
    vseq[0] = 3'b010; gexp[0] = 3'b010;
    vseq[1] = 3'b011; gexp[1] = 3'b001;
    vseq[2] = 3'b001; gexp[2] = 3'b001;
    vseq[3] = 3'b111; gexp[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      val3 = vseq[i];
      @(negedge clk);
      checks++;
      if (rdy3 !== gexp[i]) begin
        errors++;
        $display("FAIL wrap_rdy[%0d]: got %b expected %b", i, rdy3, gexp[i]);
      end
      if (i == 1) begin
        checks++;
        if (cval3 !== 1'b1) begin
          errors++;
          $display("FAIL wrap_val: got %b expected 1", cval3);
        end
      end
      @(posedge clk);
      #1;
    end
    val3 = 3'b000;
  endtask

  task automatic test_saturation();
    vals = 2'b11;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ccnts !== 4'd10) begin
      errors++;
      $display("FAIL sat_mid: got %0d expected 10", ccnts);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ccnts !== 4'd15) begin
      errors++;
      $display("FAIL sat_top: got %0d expected 15", ccnts);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ccnts !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: got %0d expected 15", ccnts);
    end
    vals = 2'b00;
    @(posedge clk);
    #1;
  endtask

  task automatic test_midstream_reset();
    set_pipe(0, 5'd17, 5'd7, 32'hC0DE_0001, 1'b1);
    set_pipe(1, 5'd18, 5'd8, 32'hC0DE_0002, 1'b1);
    step(1'b1, 2'b01);
    set_pipe(0, 5'd19, 5'd9, 32'hC0DE_0003, 1'b0);
    step(1'b0, 2'b11);
    step(1'b1, 2'b11);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
  endtask

  initial begin
    rst = 1'b0;
    val = '0; seq = '0; waddr = '0; wdata = '0; wen = '0;
    val3 = '0; seq3 = '0; waddr3 = '0; wdata3 = '0; wen3 = '0;
    vals = '0; seqs = '0; waddrs = '0; wdatas = '0; wens = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_alternation();
    test_wrap();
    test_saturation();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
